// File: rtl/clk_div_ctrl.sv
// Programmable divide-by-N clock controller: glitch-free clk_out and a tick per period.
// Divisor changes and stop requests only take effect at period boundaries.
module clk_div_ctrl #(
    parameter int W       = 8,
    parameter int DEF_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         tick,
    output logic         active,
    output logic [W-1:0] cur_div
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         pend_vld_q, pend_vld_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         active_q, active_d;
    logic         cfg_ready_q, cfg_ready_d;
    logic         cfg_err_q, cfg_err_d;

    logic         hs;
    logic         bad;
    logic         wrap;
    logic         run_d;
    logic [W:0]   half_d;

    always_comb begin
        hs   = cfg_valid & cfg_ready_q;
        bad  = hs & (cfg_div < W'(2));
        wrap = (state_q != IDLE) && (cnt_q == cur_div_q - W'(1));

        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hs && !bad) cur_div_d = cfg_div;
                if (en) state_d = RUN;
            end
            default: begin
                if (wrap) begin
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    // A divisor accepted on the wrap cycle itself skips the pending slot
                    if (pend_vld_q)       cur_div_d = pend_div_q;
                    else if (hs && !bad)  cur_div_d = cfg_div;
                end else begin
                    cnt_d = cnt_q + W'(1);
                    if (hs && !bad) begin
                        pend_div_d = cfg_div;
                        pend_vld_d = 1'b1;
                    end
                end
                if (en)                  state_d = RUN;
                else if (state_q == RUN) state_d = STOP;
                else if (wrap)           state_d = IDLE;
            end
        endcase

        // Outputs are derived from next state so every output is a plain flop
        run_d       = (state_d != IDLE);
        half_d      = ({1'b0, cur_div_d} + (W+1)'(1)) >> 1;
        clk_out_d   = run_d && ({1'b0, cnt_d} < half_d);
        tick_d      = run_d && (cnt_d == '0);
        active_d    = run_d;
        cfg_ready_d = !pend_vld_d;
        cfg_err_d   = bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_div_q   <= DEF_DIV_W;
            pend_div_q  <= '0;
            pend_vld_q  <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            active_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            pend_div_q  <= pend_div_d;
            pend_vld_q  <= pend_vld_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            active_q    <= active_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign active    = active_q;
    assign cur_div   = cur_div_q;

endmodule
